ram_writer: RTL and testbench
=============================

Name: ram_writer

Overview:
- Small writable lookup memory, 2^ADDR_WIDTH words of DATA_WIDTH bits. It is the write-side counterpart of the fixed 4-entry address-to-data lookup table driven from SWI[3:2] in the top level.
- Accepts single-word write requests and a whole-memory clear command.
- Each write is sequenced through a read-back stage and acknowledged with a done pulse.
- Provides an independent registered read port for LED display. Instantiated in top, with inputs from SWI and outputs to LED/SEG.

Parameters:
- ADDR_WIDTH, 2, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 3, bits per word.
- CNT_WIDTH, 8, width of the write-acknowledge counter.

Ports:
- clk_2  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_req  in  1  write request; sampled only in IDLE.
- wr_addr  in  ADDR_WIDTH  write address; captured with wr_req.
- wr_data  in  DATA_WIDTH  write data; captured with wr_req.
- clr_req  in  1  clear-all request; sampled only in IDLE.
- rd_addr  in  ADDR_WIDTH  read-port address.
- rd_data  out  DATA_WIDTH  registered read data.
- rb_data  out  DATA_WIDTH  read-back value of the last completed write.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a write or clear completes.
- wr_count  out  CNT_WIDTH  number of completed single-word writes; wraps.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=IDLE.
  - Memory loads defaults: mem[0]=3'b011, mem[1]=3'b110, mem[2]=3'b100, mem[3]=3'b010. For depth > 4, the remaining words load 0.
  - rd_data=0, rb_data=0, busy=0, done=0, wr_count=0.
  - Reset asserted mid-operation aborts it. No partial write is retained beyond the default load.
- FSM states: IDLE, WRITE, READBACK, CLEAR, ACK.
- IDLE:
  - clr_req=1 -> CLEAR, clear index=0. clr_req wins over a simultaneous wr_req.
  - Otherwise wr_req=1 -> WRITE, with addr/data captured into internal registers.
  - busy=0.
- WRITE (1 cycle): mem[captured addr] <= captured data -> READBACK.
- READBACK (1 cycle): rb_data <= mem[captured addr], which must equal the captured data. wr_count increments (wraps at 2**CNT_WIDTH) -> ACK.
- CLEAR:
  - Writes mem[idx] <= 0 and idx increments, one word per cycle.
  - After writing index depth-1 -> ACK. Clear takes exactly depth cycles.
  - wr_count is unchanged; rb_data is unchanged.
- ACK (1 cycle): done=1 -> IDLE.
- Single write latency: wr_req sampled at edge N gives done=1 during cycle N+3, and busy=1 for cycles N+1..N+3.
- Requests while busy are ignored, not queued. A request held high through ACK is re-sampled in the next IDLE cycle, so level-held wr_req repeats the write every 4 cycles.
- Read port:
  - rd_data <= mem[rd_addr] every edge, in all states, including while busy. Latency is 1 cycle.
  - Read-during-write to the same address returns the old data; the new data is visible the following cycle.
- Outputs are registered and glitch-free (done is a registered FSM decode).
- No widths are truncated. Address wrap-around is impossible by construction, because the index is ADDR_WIDTH wide and terminates at depth-1.

Decomposition:
- Package ram_writer_pkg holds:
  - the typedef enum logic [2:0] state_t {IDLE, WRITE, READBACK, CLEAR, ACK};
  - localparam DEFAULT_WORDS (the four reset values above).
- One sub-module, ram_writer_mem: the register-array memory, containing the async-reset default load, the synchronous write port and the registered read port.
- The FSM, capture registers and counter stay in ram_writer.

Test Plan:
- Reset then read: release reset_n, sweep rd_addr 0..3 -> rd_data = 011,110,100,010 one cycle after each address; busy=0, wr_count=0.
- Single write: wr_req with wr_addr=2, wr_data=3'b101 -> busy high 3 cycles, done pulse at N+3, rb_data=101, wr_count=1. Then rd_addr=2 gives rd_data=101.
- Ignored while busy: write addr1=3'b001, then pulse wr_req with addr3=3'b111 during WRITE -> mem[3] stays 010, wr_count=1.
- Clear priority: wr_req and clr_req together in IDLE (addr0, data 111) -> CLEAR runs 4 cycles then done. All words read 0, wr_count unchanged, mem[0]≠111.
- Read-during-write: rd_addr=2 held, write 3'b001 to addr 2 -> rd_data shows the old value on the WRITE-cycle edge and 001 on the next edge.
- Reset mid-clear: assert reset_n=0 during CLEAR cycle 2 -> immediate IDLE, busy=0, memory back to defaults, done never pulses.

Source files
------------

// File: rtl/ram_writer_pkg.sv
// Shared types and reset contents for the ram_writer lookup memory.
package ram_writer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    READBACK = 3'd2,
    CLEAR    = 3'd3,
    ACK      = 3'd4
  } state_t;

  // Element [0] is the value loaded into word 0.
  localparam logic [3:0][2:0] DEFAULT_WORDS = {3'b010, 3'b100, 3'b110, 3'b011};

  function automatic logic [2:0] default_word(input int i);
    logic [1:0] idx;
    idx = 2'(i);
    return (i < 4) ? DEFAULT_WORDS[idx] : 3'b000;
  endfunction

endpackage

// File: rtl/ram_writer_mem.sv
// Register-array memory: async default load, synchronous write port,
// registered display read port and a combinational read-back tap.
module ram_writer_mem
  import ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0] rb_word
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // rd_data samples the array before this edge's write lands, so a
  // read of the address being written returns the old word.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[ADDR_WIDTH'(i)] <= DATA_WIDTH'(default_word(i));
      end
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (we) begin
        mem[waddr] <= wdata;
      end
    end
  end

  assign rb_word = mem[rb_addr];

endmodule

// File: rtl/ram_writer.sv
// Write sequencer for the small lookup memory: single-word write with
// read-back, whole-memory clear, and a done pulse on completion.
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_2,
  input  logic                  reset_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output state_t                dbg_state
);

  localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  // Handshake: wr_req/clr_req act as valid, !busy acts as ready. A request
  // is accepted on an edge where busy is low; requests seen while busy are
  // dropped, and a level-held request is simply accepted again once idle.
  state_t                state;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [ADDR_WIDTH-1:0] clr_idx;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rb_word;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cap_addr;
    mem_wdata = cap_data;
    case (state)
      WRITE: mem_we = 1'b1;
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
      end
      default: ;
    endcase
  end

  ram_writer_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk_2   (clk_2),
    .reset_n (reset_n),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rb_addr (cap_addr),
    .rb_word (rb_word)
  );

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_data <= '0;
      clr_idx  <= '0;
      rb_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end else if (wr_req) begin
            state    <= WRITE;
            cap_addr <= wr_addr;
            cap_data <= wr_data;
            busy     <= 1'b1;
          end
        end
        WRITE: state <= READBACK;
        READBACK: begin
          rb_data  <= rb_word;
          wr_count <= wr_count + CNT_WIDTH'(1);
          state    <= ACK;
          done     <= 1'b1;
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state <= ACK;
            done  <= 1'b1;
          end else begin
            clr_idx <= clr_idx + ADDR_WIDTH'(1);
          end
        end
        ACK: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer: reference memory model, expected
// queues for read-port and read-back data, cycle-exact busy/done checks.
module tb_ram_writer;
  import ram_writer_pkg::*;

  logic       clk_2 = 1'b0;
  logic       reset_n;
  logic       wr_req;
  logic [1:0] wr_addr;
  logic [2:0] wr_data;
  logic       clr_req;
  logic [1:0] rd_addr;
  logic [2:0] rd_data;
  logic [2:0] rb_data;
  logic       busy;
  logic       done;
  logic [7:0] wr_count;
  state_t     dbg_state;

  ram_writer #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(3),
    .CNT_WIDTH (8)
  ) dut (
    .clk_2    (clk_2),
    .reset_n  (reset_n),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr_req  (clr_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rb_data  (rb_data),
    .busy     (busy),
    .done     (done),
    .wr_count (wr_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_2 = ~clk_2;

  // ---------------- scoreboard state ----------------
  logic [2:0] rd_exp_q[$];
  logic [2:0] rb_exp_q[$];
  logic [2:0] model_mem [4];
  logic [7:0] exp_count;
  logic [2:0] last_rb;
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_mem[0] = 3'b011;
    model_mem[1] = 3'b110;
    model_mem[2] = 3'b100;
    model_mem[3] = 3'b010;
    exp_count    = 8'd0;
    last_rb      = 3'b000;
    rd_exp_q.delete();
    rb_exp_q.delete();
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic read_sweep(input string tag);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      rd_exp_q.push_back(model_mem[a]);
      tick();
      check($sformatf("%s_rd%0d", tag, a), rd_data, rd_exp_q.pop_front());
    end
  endtask

  // mode 0: plain write; 1: fire a competing request while WRITE is active;
  // 2: hold rd_addr on the written address to observe read-during-write.
  task automatic do_write(input logic [1:0] a, input logic [2:0] d, input int mode);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    rb_exp_q.push_back(d);
    if (mode == 2) begin
      rd_addr = a;
      rd_exp_q.push_back(model_mem[a]);
      rd_exp_q.push_back(d);
    end
    tick();
    wr_req = 1'b0;
    check("wr_busy1", busy, 1);
    check("wr_done1", done, 0);
    if (mode == 1) begin
      wr_req  = 1'b1;
      wr_addr = 2'd3;
      wr_data = 3'b111;
    end
    tick();
    wr_req = 1'b0;
    check("wr_busy2", busy, 1);
    check("wr_done2", done, 0);
    if (mode == 2) check("rdw_old", rd_data, rd_exp_q.pop_front());
    exp_count = exp_count + 8'd1;
    model_mem[a] = d;
    last_rb = d;
    tick();
    check("wr_busy3", busy, 1);
    check("wr_done3", done, 1);
    check("wr_rb", rb_data, rb_exp_q.pop_front());
    check("wr_count", wr_count, exp_count);
    if (mode == 2) check("rdw_new", rd_data, rd_exp_q.pop_front());
    tick();
    check("wr_idle_busy", busy, 0);
    check("wr_idle_done", done, 0);
  endtask

  task automatic do_clear_with_write();
    clr_req = 1'b1;
    wr_req  = 1'b1;
    wr_addr = 2'd0;
    wr_data = 3'b111;
    tick();
    clr_req = 1'b0;
    wr_req  = 1'b0;
    check("clr_state", 32'(dbg_state), 32'(CLEAR));
    for (int c = 0; c < 4; c++) begin
      check($sformatf("clr_busy%0d", c), busy, 1);
      check($sformatf("clr_done%0d", c), done, 0);
      tick();
    end
    check("clr_done", done, 1);
    check("clr_count", wr_count, exp_count);
    check("clr_rb", rb_data, last_rb);
    for (int i = 0; i < 4; i++) model_mem[i] = 3'b000;
    tick();
    check("clr_idle", busy, 0);
  endtask

  task automatic held_write(input logic [1:0] a, input logic [2:0] d);
    int dones = 0;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) dones++;
    end
    wr_req = 1'b0;
    exp_count = exp_count + 8'd2;
    model_mem[a] = d;
    last_rb = d;
    check("held_dones", dones, 2);
    check("held_idle", busy, 0);
    check("held_count", wr_count, exp_count);
    check("held_rb", rb_data, last_rb);
  endtask

  task automatic reset_mid_clear();
    int dones = 0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_count", wr_count, 0);
    check("rst_rb", rb_data, 0);
    check("rst_rd", rd_data, 0);
    repeat (2) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk_2);
    @(negedge clk_2);
    reset_n = 1'b1;
    #1;
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_count", wr_count, 0);
    check("init_rd", rd_data, 0);
    check("init_rb", rb_data, 0);
    check("init_state", 32'(dbg_state), 32'(IDLE));
    read_sweep("reset");

    do_write(2'd2, 3'b101, 0);
    read_sweep("single");

    do_write(2'd1, 3'b001, 1);
    read_sweep("ignored");

    do_clear_with_write();
    read_sweep("clear");

    do_write(2'd2, 3'b110, 0);
    do_write(2'd2, 3'b001, 2);

    held_write(2'd0, 3'b101);
    read_sweep("held");

    for (int k = 0; k < 4; k++) begin
      do_write(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 0);
    end
    read_sweep("rand");

    reset_mid_clear();
    check("post_rst_count", wr_count, 0);
    read_sweep("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
